// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: byte/half/word access, lane steering, bus timeout (optional LSU_MISALIGN_TRAP_EN)
module lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    // The counter can reach TIMEOUT_CYCLES when a grant wins on the last allowed cycle.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    state_e           state_q, state_d;

    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       req_off;
    logic             req_illegal;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic [31:0]      lane;
    logic [31:0]      load_ext;
    logic             tmo;

    // Decode an incoming request: legality, effective lane offset, byte enables, replicated store data.
    always_comb begin
        req_off     = addr_i[1:0];
        req_illegal = (size_i == SIZE_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size_i == SIZE_HALF && addr_i[0]) begin
            req_illegal = 1'b1;
        end
        if (size_i == SIZE_WORD && addr_i[1:0] != 2'b00) begin
            req_illegal = 1'b1;
        end
`else
        // Misaligned accesses are silently force-aligned to their natural boundary.
        if (size_i == SIZE_HALF) begin
            req_off = {addr_i[1], 1'b0};
        end
        if (size_i == SIZE_WORD) begin
            req_off = 2'b00;
        end
`endif
        case (size_i)
            SIZE_BYTE: begin
                req_be    = 4'b0001 << req_off;
                req_wdata = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                req_be    = 4'b0011 << req_off;
                req_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = wdata_i;
            end
        endcase
    end

    // Select the addressed lane of the raw read word and extend it to 32 bits.
    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            SIZE_BYTE: load_ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SIZE_HALF: load_ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default:   load_ext = lane;
        endcase
    end

    assign tmo = (cnt_q >= CNT_LAST);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; grant/response take priority over an expiring timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = req_illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end else if (tmo) begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i || tmo) begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction registers: request fields, timeout counter, captured result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Compute the next values of the transaction registers for each state.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    off_d   = req_off;
                    addr_d  = {addr_i[31:2], 2'b00};
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_illegal;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (!mem_gnt_i && tmo) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    err_d   = mem_err_i;
                    rdata_d = (we_q || mem_err_i) ? 32'h0 : load_ext;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs decoded from state and registers only.
    always_comb begin
        ready_o     = (state_q == S_IDLE);
        done_o      = (state_q == S_RESP);
        err_o       = (state_q == S_RESP) && err_q;
        rdata_o     = (state_q == S_RESP) ? rdata_q : 32'h0;
        mem_req_o   = (state_q == S_REQ);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against a behavioural access model
module tb_lsu;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int checks   = 0;
    int failures = 0;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One access: g = cycles the grant is withheld, r = cycles from grant to response.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int g, input int r, input logic [31:0] mrd, input logic merr,
                           output int done_at, output logic [3:0] be_seen,
                           output logic [31:0] addr_seen, output logic [31:0] wd_seen,
                           output logic [31:0] rd_seen, output logic err_seen);
        logic        legal;
        int          off;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_addr;
        logic [31:0] e_rd;
        logic [31:0] ext;
        logic        e_err;
        int          e_done;
        int          e_req_last;
        int          last;
        longint      v;

        legal = (size != 2'b11);
        off   = int'(addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == 2'b01 && addr[0]) legal = 1'b0;
        if (size == 2'b10 && addr[1:0] != 2'b00) legal = 1'b0;
`else
        if (size == 2'b01) off = off & 2;
        if (size == 2'b10) off = 0;
`endif
        e_addr = addr & 32'hFFFF_FFFC;
        v = longint'(mrd >> (8 * off));
        case (size)
            2'b00: begin
                e_be = 4'(1 << off);
                e_wd = (wdata & 32'hFF) * 32'h0101_0101;
                v = v & 'hFF;
                if (!uns && v >= 128) v = v - 256;
            end
            2'b01: begin
                e_be = 4'(3 << off);
                e_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
                v = v & 'hFFFF;
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: begin
                e_be = 4'hF;
                e_wd = wdata;
            end
        endcase
        ext = v[31:0];

        if (!legal) begin
            e_done = 1; e_req_last = 0; e_err = 1'b1; e_rd = 32'h0;
        end else if (g > TO - 1) begin
            e_done = TO + 1; e_req_last = TO; e_err = 1'b1; e_rd = 32'h0;
        end else begin
            int lim;
            lim = (g + 1 > TO - 1) ? g + 1 : TO - 1;
            e_req_last = g + 1;
            if (g + 1 + r <= lim) begin
                e_done = g + r + 3;
                e_err  = merr;
                e_rd   = (we || merr) ? 32'h0 : ext;
            end else begin
                e_done = lim + 2; e_err = 1'b1; e_rd = 32'h0;
            end
        end
        last = ((e_done > g + 2 + r) ? e_done : g + 2 + r) + 1;

        done_at = -1; be_seen = 4'h0; addr_seen = 32'h0; wd_seen = 32'h0;
        rd_seen = 32'h0; err_seen = 1'b0;

        @(negedge clk_i);
        check_eq("accept_ready", {31'b0, ready_o}, 32'd1);
        req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk_i);
            check_eq("ready", {31'b0, ready_o}, {31'b0, cyc > e_done});
            check_eq("done", {31'b0, done_o}, {31'b0, cyc == e_done});
            check_eq("mem_req", {31'b0, mem_req_o}, {31'b0, legal && cyc <= e_req_last});
            if (mem_req_o) begin
                check_eq("mem_addr", mem_addr_o, e_addr);
                check_eq("mem_be", {28'b0, mem_be_o}, {28'b0, e_be});
                check_eq("mem_we", {31'b0, mem_we_o}, {31'b0, we});
                if (we) check_eq("mem_wdata", mem_wdata_o, e_wd);
                be_seen = mem_be_o; addr_seen = mem_addr_o; wd_seen = mem_wdata_o;
            end
            if (done_o) begin
                done_at = cyc; rd_seen = rdata_o; err_seen = err_o;
                check_eq("err", {31'b0, err_o}, {31'b0, e_err});
                check_eq("rdata", rdata_o, e_rd);
            end
            req_i        = 1'b0;
            we_i         = 1'($urandom);
            size_i       = 2'($urandom);
            unsigned_i   = 1'($urandom);
            addr_i       = $urandom;
            wdata_i      = $urandom;
            mem_gnt_i    = (cyc == g + 1);
            mem_rvalid_i = (cyc == g + 2 + r);
            mem_rdata_i  = (cyc == g + 2 + r) ? mrd : $urandom;
            mem_err_i    = (cyc == g + 2 + r) ? merr : 1'($urandom);
        end
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask

    int          d_at;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wd_s, rd_s;
    logic        err_s;

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0; mem_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_ready", {31'b0, ready_o}, 32'd1);
        check_eq("rst_done", {31'b0, done_o}, 32'd0);
        check_eq("rst_err", {31'b0, err_o}, 32'd0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        check_eq("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check_eq("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'h0);
        check_eq("rst_mem_be", {28'b0, mem_be_o}, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata_o, 32'h0);
        rst_ni = 1'b1;

        // Signed byte load from the top lane.
        run_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 0, 32'h80AA_BBCC, 1'b0,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
        check_eq("lb_be", {28'b0, be_s}, 32'h8);
        check_eq("lb_rdata", rd_s, 32'hFFFF_FF80);
        check_eq("lb_done_cycle", d_at, 32'd3);

        // Half store to the upper half.
        run_txn(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 1'b0,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
        check_eq("sh_be", {28'b0, be_s}, 32'hC);
        check_eq("sh_wdata", wd_s, 32'h5678_5678);
        check_eq("sh_addr", addr_s, 32'h2000);
        check_eq("sh_rdata", rd_s, 32'h0);

        // Grant on the last allowed cycle, response right after: both win over the timeout.
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4440, 32'h0, TO - 1, 0, 32'hCAFE_F00D, 1'b0,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
        check_eq("stall_rdata", rd_s, 32'hCAFE_F00D);
        check_eq("stall_err", {31'b0, err_s}, 32'd0);

        // Response coinciding with timeout expiry.
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_5006, 32'h0, 0, TO - 2, 32'h8001_0002, 1'b0,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
        check_eq("edge_rdata", rd_s, 32'h0000_8001);

        // No grant at all: timeout abort.
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 20, 0, 32'h1111_2222, 1'b0,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
        check_eq("tmo_done_cycle", d_at, 32'd5);
        check_eq("tmo_err", {31'b0, err_s}, 32'd1);

        // Misaligned word load.
        run_txn(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 0, 0, 32'h7654_3210, 1'b0,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("mis_done_cycle", d_at, 32'd1);
        check_eq("mis_err", {31'b0, err_s}, 32'd1);
`else
        check_eq("mis_addr", addr_s, 32'h3000);
        check_eq("mis_be", {28'b0, be_s}, 32'hF);
`endif

        // Bus error on a load response.
        run_txn(1'b0, 2'b10, 1'b0, 32'h7000, 32'h0, 1, 0, 32'h5555_AAAA, 1'b1,
                d_at, be_s, addr_s, wd_s, rd_s, err_s);
        check_eq("berr_err", {31'b0, err_s}, 32'd1);
        check_eq("berr_rdata", rd_s, 32'h0);

        // Asynchronous reset in REQ (p=0) and in WAIT (p=1), then a stale response.
        for (int p = 0; p < 2; p++) begin
            @(negedge clk_i);
            req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h8000; unsigned_i = 1'b0;
            @(negedge clk_i);
            req_i = 1'b0;
            check_eq("rst_mid_req_on", {31'b0, mem_req_o}, 32'd1);
            mem_gnt_i = (p == 1);
            @(negedge clk_i);
            mem_gnt_i = 1'b0;
            #2 rst_ni = 1'b0;
            #1;
            check_eq("rst_mid_mem_req", {31'b0, mem_req_o}, 32'd0);
            check_eq("rst_mid_ready", {31'b0, ready_o}, 32'd1);
            @(negedge clk_i);
            rst_ni = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            check_eq("stale_done", {31'b0, done_o}, 32'd0);
            check_eq("stale_ready", {31'b0, ready_o}, 32'd1);
        end

        // Randomized accesses, including reserved size, errors and timeouts.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 7) == 0), d_at, be_s, addr_s, wd_s, rd_s, err_s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
